// File: rtl/alu_issue_seq_if.sv
// Request, ALU-drive and response bundle for alu_issue_seq.
// The slave side is the sequencer and the master side is its environment.
interface alu_issue_seq_if #(
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_opa;
  logic [DW-1:0] req_opb;
  logic [CW-1:0] req_cmd;
  logic          req_mode;
  logic          req_cin;
  logic          req_split;
  logic [4:0]    req_gap;

  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [CW-1:0] cmd;
  logic          mode;
  logic          cin;
  logic          ce;
  logic [1:0]    inp_valid;

  logic [DW+1:0] res;
  logic          cout;
  logic          oflow;
  logic          g;
  logic          e;
  logic          l;
  logic          err;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW+1:0] rsp_res;
  logic [5:0]    rsp_flags;
  logic          rsp_tmo;

  modport slave (
    input  req_valid, req_opa, req_opb, req_cmd,
    input  req_mode, req_cin, req_split, req_gap,
    output req_ready,
    output opa, opb, cmd, mode, cin, ce, inp_valid,
    input  res, cout, oflow, g, e, l, err,
    output rsp_valid, rsp_res, rsp_flags, rsp_tmo,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_opa, req_opb, req_cmd,
    output req_mode, req_cin, req_split, req_gap,
    input  req_ready,
    input  opa, opb, cmd, mode, cin, ce, inp_valid,
    output res, cout, oflow, g, e, l, err,
    input  rsp_valid, rsp_res, rsp_flags, rsp_tmo,
    output rsp_ready
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issues one ALU transaction at a time, optionally with split operands,
// waits out the ALU latency and holds the captured result for the requester.
module alu_issue_seq #(
  parameter int DW  = 8,
  parameter int CW  = 4,
  parameter int TMO = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_seq_if.slave s_bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSA  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_ISSB  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam logic [5:0] TMO_W = 6'(TMO);

  logic [2:0]    r_state;
  logic [DW-1:0] r_opb;
  logic [DW-1:0] r_opa_o;
  logic [DW-1:0] r_opb_o;
  logic [CW-1:0] r_cmd;
  logic          r_mode;
  logic          r_cin;
  logic          r_split;
  logic [4:0]    r_gap;
  logic [4:0]    r_gcnt;
  logic [1:0]    r_wcnt;
  logic [DW+1:0] r_rsp_res;
  logic [5:0]    r_rsp_flags;
  logic          r_rsp_tmo;

  logic          w_long;
  logic [1:0]    w_wload;
  logic [DW+1:0] w_res_c;
  logic [5:0]    w_flags_c;

  // Undriven or unknown result bits are captured as 0
  function automatic logic f_clean(input logic b);
    case (b)
      1'b1:    f_clean = 1'b1;
      default: f_clean = 1'b0;
    endcase
  endfunction

  assign w_long  = r_mode &&
                   (r_cmd == CW'(9) || r_cmd == CW'(10));
  assign w_wload = w_long ? 2'd2 : 2'd1;

  always_comb begin
    w_res_c = '0;
    for (int i = 0; i < DW + 2; i++)
      w_res_c[i] = f_clean(s_bus.res[i]);
    w_flags_c = {f_clean(s_bus.cout),
                 f_clean(s_bus.oflow),
                 f_clean(s_bus.g),
                 f_clean(s_bus.e),
                 f_clean(s_bus.l),
                 f_clean(s_bus.err)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_opb       <= '0;
      r_opa_o     <= '0;
      r_opb_o     <= '0;
      r_cmd       <= '0;
      r_mode      <= 1'b0;
      r_cin       <= 1'b0;
      r_split     <= 1'b0;
      r_gap       <= '0;
      r_gcnt      <= '0;
      r_wcnt      <= '0;
      r_rsp_res   <= '0;
      r_rsp_flags <= '0;
      r_rsp_tmo   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (s_bus.req_valid) begin
            r_opb   <= s_bus.req_opb;
            r_opa_o <= s_bus.req_opa;
            if (!s_bus.req_split)
              r_opb_o <= s_bus.req_opb;
            r_cmd   <= s_bus.req_cmd;
            r_mode  <= s_bus.req_mode;
            r_cin   <= s_bus.req_cin;
            r_split <= s_bus.req_split;
            r_gap   <= s_bus.req_gap;
            r_state <= S_ISSA;
          end
        end
        S_ISSA: begin
          if (!r_split) begin
            r_wcnt  <= w_wload;
            r_state <= S_WAIT;
          end else if (r_gap == 5'd0) begin
            r_opb_o <= r_opb;
            r_state <= S_ISSB;
          end else begin
            r_gcnt  <= r_gap - 5'd1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gcnt == 5'd0) begin
            r_opb_o <= r_opb;
            r_state <= S_ISSB;
          end else begin
            r_gcnt <= r_gcnt - 5'd1;
          end
        end
        S_ISSB: begin
          r_wcnt  <= w_wload;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wcnt == 2'd0) begin
            r_rsp_res   <= w_res_c;
            r_rsp_flags <= w_flags_c;
            r_rsp_tmo   <= r_split &&
                           ({1'b0, r_gap} >= TMO_W);
            r_state     <= S_RESP;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
          end
        end
        S_RESP: begin
          if (s_bus.rsp_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_bus.req_ready = (r_state == S_IDLE);
  assign s_bus.opa       = r_opa_o;
  assign s_bus.opb       = r_opb_o;
  assign s_bus.cmd       = r_cmd;
  assign s_bus.mode      = r_mode;
  assign s_bus.cin       = r_cin;
  assign s_bus.ce        = (r_state == S_ISSA) ||
                           (r_state == S_GAP)  ||
                           (r_state == S_ISSB) ||
                           (r_state == S_WAIT);
  assign s_bus.inp_valid =
    (r_state == S_ISSA) ? (r_split ? 2'b01 : 2'b11) :
    (r_state == S_ISSB) ? 2'b10 : 2'b00;
  assign s_bus.rsp_valid = (r_state == S_RESP);
  assign s_bus.rsp_res   = r_rsp_res;
  assign s_bus.rsp_flags = r_rsp_flags;
  assign s_bus.rsp_tmo   = r_rsp_tmo;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq with a small behavioural ALU
// that captures operands on the sequencer's inp_valid strobes.
module tb_alu_issue_seq;

  logic clk;
  logic rst_n;

  alu_issue_seq_if #(.DW(8), .CW(4)) bus ();

  alu_issue_seq #(.DW(8), .CW(4), .TMO(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  logic [16:0] exp_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: cmd9 = (a+1)*(b+1), cmd10 = (a<<1)*b
  logic [7:0] m_a;
  logic [7:0] m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0;
      m_b <= '0;
    end else begin
      if (bus.inp_valid[0]) m_a <= bus.opa;
      if (bus.inp_valid[1]) m_b <= bus.opb;
    end
  end

  always_comb begin
    logic [17:0] t;
    t = '0;
    bus.res = '0;
    bus.cout = 1'b0;
    bus.oflow = 1'b0;
    bus.g = 1'b0;
    bus.e = 1'b0;
    bus.l = 1'b0;
    bus.err = 1'b0;
    if (bus.mode) begin
      case (bus.cmd)
        4'd0: begin
          t = {10'd0, m_a} + {10'd0, m_b} + {17'd0, bus.cin};
          bus.res = t[9:0];
          bus.cout = t[8];
          bus.oflow = (m_a[7] == m_b[7]) && (t[7] != m_a[7]);
        end
        4'd9: begin
          t = ({10'd0, m_a} + 18'd1) * ({10'd0, m_b} + 18'd1);
          bus.res = t[9:0];
        end
        4'd10: begin
          t = {9'd0, m_a, 1'b0} * {10'd0, m_b};
          bus.res = t[9:0];
        end
        default: bus.err = 1'b1;
      endcase
    end else begin
      case (bus.cmd)
        4'd0: bus.res = {2'b00, m_a & m_b};
        4'd1: bus.res = {2'b00, m_a | m_b};
        4'd2: bus.res = {2'b00, m_a ^ m_b};
        default: bus.err = 1'b1;
      endcase
    end
  end

  // Monitor: pops one expectation per completed response handshake
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected rsp", 32'(bus.rsp_res), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_res", 32'(bus.rsp_res), 32'(e[16:7]));
        chk("rsp_flags", 32'(bus.rsp_flags), 32'(e[6:1]));
        chk("rsp_tmo", 32'(bus.rsp_tmo), 32'(e[0]));
      end
    end
  end

  task automatic accept(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] cmd, input logic mode,
                        input logic cin, input logic split,
                        input logic [4:0] gap);
    int n;
    @(negedge clk);
    bus.req_opa = a;
    bus.req_opb = b;
    bus.req_cmd = cmd;
    bus.req_mode = mode;
    bus.req_cin = cin;
    bus.req_split = split;
    bus.req_gap = gap;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] cmd, input logic mode,
                     input logic cin, input logic split,
                     input logic [4:0] gap, input logic [9:0] eres,
                     input logic [5:0] eflg, input logic etmo,
                     input int bp);
    int w, lat, n, bad, m;
    logic [1:0] eiv;
    logic [9:0] hold;
    w = (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 3 : 2;
    lat = split ? int'(gap) + w + 3 : w + 2;
    exp_q.push_back({eres, eflg, etmo});
    bus.rsp_ready = (bp == 0);
    accept(a, b, cmd, mode, cin, split, gap);
    n = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.rsp_valid) begin
        eiv = 2'b00;
        if (n == 1) eiv = split ? 2'b01 : 2'b11;
        if (split && n == int'(gap) + 2) eiv = 2'b10;
        if (bus.inp_valid !== eiv || bus.ce !== 1'b1 ||
            bus.req_ready !== 1'b0)
          bad++;
      end
    end while (!bus.rsp_valid && n < 100);
    chk("latency", 32'(n), 32'(lat));
    chk("issue sequence", 32'(bad), 32'd0);
    if (bp > 0) begin
      hold = bus.rsp_res;
      bad = 0;
      bus.req_valid = 1'b1;
      bus.req_opa = 8'h55;
      repeat (bp) begin
        @(negedge clk);
        if (!bus.rsp_valid || bus.rsp_res !== hold ||
            bus.req_ready || bus.inp_valid !== 2'b00 || bus.ce)
          bad++;
      end
      bus.req_valid = 1'b0;
      chk("backpressure hold", 32'(bad), 32'd0);
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
    end
    m = 0;
    while (bus.rsp_valid && m < 20) begin
      @(negedge clk);
      m++;
    end
    chk("rsp release", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int bad;
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_opa = '0;
    bus.req_opb = '0;
    bus.req_cmd = '0;
    bus.req_mode = 1'b0;
    bus.req_cin = 1'b0;
    bus.req_split = 1'b0;
    bus.req_gap = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_res", 32'(bus.rsp_res), 32'd0);
    chk("reset rsp_flags", 32'(bus.rsp_flags), 32'd0);
    chk("reset inp/ce", 32'({bus.inp_valid, bus.ce}), 32'd0);
    chk("reset opa/opb", 32'({bus.opa, bus.opb}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);

    run(8'hFF, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0,
        10'h100, 6'b100000, 1'b0, 0);
    run(8'd3, 8'd4, 4'd9, 1'b1, 1'b0, 1'b0, 5'd0,
        10'd20, 6'b000000, 1'b0, 0);
    run(8'hF0, 8'h3C, 4'd0, 1'b0, 1'b0, 1'b1, 5'd5,
        10'h030, 6'b000000, 1'b0, 0);
    run(8'h10, 8'h20, 4'd0, 1'b1, 1'b1, 1'b1, 5'd16,
        10'h031, 6'b000000, 1'b1, 0);
    run(8'h0F, 8'hA0, 4'd1, 1'b0, 1'b0, 1'b1, 5'd15,
        10'h0AF, 6'b000000, 1'b0, 0);
    run(8'h5A, 8'hFF, 4'd2, 1'b0, 1'b0, 1'b1, 5'd0,
        10'h0A5, 6'b000000, 1'b0, 0);
    run(8'd3, 8'd5, 4'd10, 1'b1, 1'b0, 1'b0, 5'd0,
        10'd30, 6'b000000, 1'b0, 0);
    run(8'h7F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b1, 5'd31,
        10'h080, 6'b010000, 1'b1, 0);
    run(8'hFF, 8'h0F, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0,
        10'h00F, 6'b000000, 1'b0, 10);
    run(8'h12, 8'h34, 4'd15, 1'b0, 1'b0, 1'b1, 5'd20,
        10'h000, 6'b000001, 1'b1, 0);

    // Reset in the middle of a split gap: transaction must vanish
    accept(8'hAA, 8'h55, 4'd0, 1'b1, 1'b0, 1'b1, 5'd20);
    repeat (4) @(negedge clk);
    chk("gap ce before reset", 32'(bus.ce), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst inp/ce", 32'({bus.inp_valid, bus.ce}), 32'd0);
    chk("async rst opa/cmd", 32'({bus.opa, bus.cmd, bus.mode}), 32'd0);
    chk("async rst req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.ce) bad++;
    end
    chk("no rsp after reset", 32'(bad), 32'd0);
    run(8'h01, 8'h02, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0,
        10'h003, 6'b000000, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
